// File: rtl/mm_result_reducer.sv
// mm_result_reducer: buffers finished Montgomery products and applies the
// final conditional subtraction limb-serially before a valid/ready handoff.
module mm_result_reducer #(
    parameter int M_SIZE = 3072,
    parameter int LIMB   = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mm_done,
    input  logic [M_SIZE-1:0] mm_c,
    input  logic [7:0]        mm_info,
    input  logic [M_SIZE-1:0] m,
    input  logic              res_ready,
    input  logic              clr_err,
    output logic              res_valid,
    output logic [M_SIZE-1:0] res_c,
    output logic [7:0]        res_info,
    output logic              cap_full,
    output logic              busy,
    output logic              overflow
);
    localparam int NUM_LIMB = M_SIZE / LIMB;
    localparam int KW = (NUM_LIMB > 1) ? $clog2(NUM_LIMB) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NUM_LIMB - 1);

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        OUT
    } state_t;

    state_t state, state_nx;

    logic              cap_valid;
    logic [M_SIZE-1:0] cap_c;
    logic [7:0]        cap_info;
    logic [M_SIZE-1:0] c_reg;
    logic [M_SIZE-1:0] d_reg;
    logic [M_SIZE-1:0] d_full;
    logic [7:0]        tag;
    logic [KW-1:0]     k;
    logic              borrow;
    logic              pop;
    logic              capture;
    logic              drop;
    logic              last;
    logic [LIMB-1:0]   c_limb;
    logic [LIMB-1:0]   m_limb;
    logic [LIMB-1:0]   d_limb;
    logic              b_out;

    assign c_limb = c_reg[int'(k)*LIMB +: LIMB];
    assign m_limb = m[int'(k)*LIMB +: LIMB];
    assign {b_out, d_limb} = {1'b0, c_limb} - {1'b0, m_limb}
                           - {{LIMB{1'b0}}, borrow};
    assign last = (k == K_LAST);

    // Difference vector including the limb being produced this cycle
    always_comb begin
        d_full = d_reg;
        d_full[int'(k)*LIMB +: LIMB] = d_limb;
    end

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        unique case (state)
            IDLE: begin
                if (cap_valid) begin
                    pop      = 1'b1;
                    state_nx = SUB;
                end
            end
            SUB: begin
                if (last) state_nx = OUT;
            end
            OUT: begin
                if (res_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign capture = mm_done & (~cap_valid | pop);
    assign drop    = mm_done & cap_valid & ~pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_valid <= 1'b0;
            cap_c     <= '0;
            cap_info  <= '0;
            overflow  <= 1'b0;
        end else begin
            if (capture) begin
                cap_valid <= 1'b1;
                cap_c     <= mm_c;
                cap_info  <= mm_info;
            end else if (pop) begin
                cap_valid <= 1'b0;
            end
            if (drop)         overflow <= 1'b1;
            else if (clr_err) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_reg    <= '0;
            d_reg    <= '0;
            tag      <= '0;
            k        <= '0;
            borrow   <= 1'b0;
            res_c    <= '0;
            res_info <= '0;
        end else if (pop) begin
            c_reg  <= cap_c;
            tag    <= cap_info;
            k      <= '0;
            borrow <= 1'b0;
        end else if (state == SUB) begin
            d_reg  <= d_full;
            borrow <= b_out;
            k      <= k + 1'b1;
            // A final borrow means c < m, so c passes through untouched
            if (last) begin
                res_c    <= b_out ? c_reg : d_full;
                res_info <= tag;
            end
        end
    end

    assign res_valid = (state == OUT);
    assign cap_full  = cap_valid;
    assign busy      = (state != IDLE) | cap_valid;

endmodule

// File: tb/tb_mm_result_reducer.sv
// Bench for mm_result_reducer: job-level reference model with per-cycle
// output comparison, plus directed boundary and handshake scenarios.
module tb_mm_result_reducer;
    localparam int M  = 3072;
    localparam int L  = 128;
    localparam int NL = M / L;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mm_done = 1'b0;
    logic [M-1:0]  mm_c = '0;
    logic [7:0]    mm_info = '0;
    logic [M-1:0]  m = '0;
    logic          res_ready = 1'b0;
    logic          clr_err = 1'b0;
    logic          res_valid;
    logic [M-1:0]  res_c;
    logic [7:0]    res_info;
    logic          cap_full;
    logic          busy;
    logic          overflow;

    int total = 0;
    int bad = 0;

    mm_result_reducer #(.M_SIZE(M), .LIMB(L)) dut (
        .clk(clk), .rst_n(rst_n), .mm_done(mm_done), .mm_c(mm_c),
        .mm_info(mm_info), .m(m), .res_ready(res_ready),
        .clr_err(clr_err), .res_valid(res_valid), .res_c(res_c),
        .res_info(res_info), .cap_full(cap_full), .busy(busy),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] fold(input logic [M-1:0] v);
        logic [63:0] f = '0;
        for (int i = 0; i < M / 64; i++) f ^= v[i*64 +: 64];
        return f;
    endfunction

    function automatic logic [M-1:0] red(input logic [M-1:0] c,
                                         input logic [M-1:0] mm);
        return (c >= mm) ? c - mm : c;
    endfunction

    function automatic logic [M-1:0] rand_wide();
        logic [M-1:0] r;
        for (int i = 0; i < M / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] a,
                       input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, a, e, $time);
        end
    endtask

    task automatic chkw(input string nm, input logic [M-1:0] a,
                        input logic [M-1:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s act=lo:%h/fold:%h exp=lo:%h/fold:%h t=%0t",
                     nm, a[63:0], fold(a), e[63:0], fold(e), $time);
        end
    endtask

    // Reference model: job buffer plus engine phase (idle/compute/out)
    int           mph = 0;
    int           mcnt = 0;
    bit           mbq = 1'b0;
    bit           mov = 1'b0;
    logic [M-1:0] mbc = '0;
    logic [M-1:0] mec = '0;
    logic [7:0]   mbi = '0;
    logic [7:0]   mei = '0;

    always @(posedge clk or negedge rst_n) begin : mdl
        int ph, cnt;
        bit bq, ov, pop, drop;
        logic [M-1:0] bc, ec;
        logic [7:0] bi, ei;
        if (!rst_n) begin
            mph <= 0;
            mcnt <= 0;
            mbq <= 1'b0;
            mov <= 1'b0;
        end else begin
            ph = mph; cnt = mcnt; bq = mbq; ov = mov;
            bc = mbc; bi = mbi; ec = mec; ei = mei;
            pop = (ph == 0) && bq;
            if (pop) begin
                ph = 1; cnt = NL; ec = red(bc, m); ei = bi;
            end else if (ph == 1) begin
                cnt--;
                if (cnt == 0) ph = 2;
            end else if (ph == 2 && res_ready) begin
                ph = 0;
            end
            drop = mm_done && bq && !pop;
            if (mm_done && !drop) begin
                bq = 1'b1; bc = mm_c; bi = mm_info;
            end else if (pop) begin
                bq = 1'b0;
            end
            if (drop) ov = 1'b1;
            else if (clr_err) ov = 1'b0;
            mph <= ph; mcnt <= cnt; mbq <= bq; mov <= ov;
            mbc <= bc; mbi <= bi; mec <= ec; mei <= ei;
        end
    end

    always @(negedge clk) begin
        chk("res_valid", 64'(res_valid), 64'(mph == 2));
        chk("cap_full", 64'(cap_full), 64'(mbq));
        chk("busy", 64'(busy), 64'(mph != 0 || mbq));
        chk("overflow", 64'(overflow), 64'(mov));
        if (mph == 2) begin
            chkw("res_c", res_c, mec);
            chk("res_info", 64'(res_info), 64'(mei));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [M-1:0] c, input logic [7:0] t);
        mm_c = c; mm_info = t; mm_done = 1'b1;
        tick;
        mm_done = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!res_valid && n < 200) begin
            tick;
            n++;
        end
        if (!res_valid) begin
            total++;
            bad++;
            $display("FAIL wait_valid timeout act=0 exp=1");
        end
    endtask

    task automatic accept;
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
    endtask

    task automatic job(input logic [M-1:0] c, input logic [7:0] t,
                       input logic [M-1:0] e, input string nm);
        int n;
        pulse(c, t);
        wait_valid(n);
        chkw(nm, res_c, e);
        chk({nm, "_tag"}, 64'(res_info), 64'(t));
        accept;
    endtask

    initial begin : stim
        logic [M-1:0] mv, m2, ec;
        int n, hits;
        repeat (3) tick;
        chk("rst_valid", 64'(res_valid), 64'(0));
        chkw("rst_res_c", res_c, '0);
        chk("rst_info", 64'(res_info), 64'(0));
        chk("rst_cap", 64'(cap_full), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_ovf", 64'(overflow), 64'(0));
        rst_n = 1'b1;
        tick;

        mv = '0; mv[M-1] = 1'b1; mv[0] = 1'b1;
        m = mv;
        pulse(mv + M'(5), 8'h3A);
        wait_valid(n);
        chk("latency", 64'(n), 64'(25));
        chkw("plus5", res_c, M'(5));
        chk("plus5_tag", 64'(res_info), 64'(8'h3A));
        accept;
        chk("valid_drop", 64'(res_valid), 64'(0));

        job(mv - M'(1), 8'h01, mv - M'(1), "m_minus1");
        job(mv, 8'h02, '0, "eq_m");
        job('0, 8'h03, '0, "zero");

        m2 = '0; m2[M-1] = 1'b1; m2[L-1:0] = '1;
        m = m2;
        job(m2 + (M'(1) << L), 8'h04, M'(1) << L, "ripple_hi");
        job(m2 + M'(1), 8'h05, M'(1), "ripple_lo");

        // backpressure
        pulse(rand_wide(), 8'h77);
        wait_valid(n);
        repeat (50) tick;
        chk("bp_hold", 64'(res_valid), 64'(1));
        chk("bp_tag", 64'(res_info), 64'(8'h77));
        accept;
        chk("bp_drop", 64'(res_valid), 64'(0));

        // three pulses, third dropped
        pulse(rand_wide(), 8'h01);
        tick;
        pulse(rand_wide(), 8'h02);
        tick;
        pulse(rand_wide(), 8'h03);
        chk("ovf_set", 64'(overflow), 64'(1));
        chk("ovf_cap", 64'(cap_full), 64'(1));
        wait_valid(n);
        chk("order1", 64'(res_info), 64'(8'h01));
        accept;
        wait_valid(n);
        chk("order2", 64'(res_info), 64'(8'h02));
        accept;
        repeat (3) tick;
        chk("ovf_sticky", 64'(overflow), 64'(1));
        chk("no_third", 64'(busy), 64'(0));
        clr_err = 1'b1;
        tick;
        clr_err = 1'b0;
        chk("ovf_clr", 64'(overflow), 64'(0));

        // capture in the same cycle as pop
        pulse(rand_wide(), 8'h11);
        tick;
        pulse(rand_wide(), 8'h22);
        wait_valid(n);
        chk("sc_first", 64'(res_info), 64'(8'h11));
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
        pulse(rand_wide(), 8'h33);
        chk("sc_ovf", 64'(overflow), 64'(0));
        chk("sc_cap", 64'(cap_full), 64'(1));
        wait_valid(n);
        chk("sc_second", 64'(res_info), 64'(8'h22));
        accept;
        wait_valid(n);
        chk("sc_third", 64'(res_info), 64'(8'h33));
        accept;

        // reset while at limb 10 with a buffered job
        pulse(rand_wide(), 8'h44);
        tick;
        pulse(rand_wide(), 8'h55);
        repeat (9) tick;
        rst_n = 1'b0;
        #1;
        chk("mid_valid", 64'(res_valid), 64'(0));
        chkw("mid_res_c", res_c, '0);
        chk("mid_info", 64'(res_info), 64'(0));
        chk("mid_cap", 64'(cap_full), 64'(0));
        chk("mid_busy", 64'(busy), 64'(0));
        chk("mid_ovf", 64'(overflow), 64'(0));
        repeat (2) tick;
        rst_n = 1'b1;
        hits = 0;
        for (int i = 0; i < 100; i++) begin
            tick;
            if (res_valid) hits++;
        end
        chk("post_rst_quiet", 64'(hits), 64'(0));

        // random traffic
        mv = rand_wide();
        mv[M-1] = 1'b1; mv[0] = 1'b1;
        m = mv;
        for (int i = 0; i < 3000; i++) begin
            mm_c = rand_wide();
            mm_info = 8'($urandom);
            mm_done = (!mbq && ($urandom % 6 == 0))
                   || ($urandom % 80 == 0);
            res_ready = ($urandom % 3 != 0);
            clr_err = ($urandom % 16 == 0);
            tick;
        end
        mm_done = 1'b0;
        clr_err = 1'b0;
        res_ready = 1'b1;
        repeat (100) tick;
        res_ready = 1'b0;
        chk("drain_busy", 64'(busy), 64'(0));

        ec = red(mv + M'(9), mv);
        chkw("model_pin", ec, M'(9));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mm_result_reducer.md
# mm_result_reducer

Downstream stage of the pipelined Montgomery multiplier top. It captures each finished product and its 8-bit job tag when `mm_done` pulses, and performs the final conditional subtraction (c ≥ m ? c − m : c) serially in LIMB-bit limbs. It then presents the fully reduced result on a valid/ready output port. A one-entry capture buffer decouples the multiplier's done pulse from downstream backpressure.

## Interface
- `M_SIZE`, 3072: operand and modulus width.
- `LIMB`, 128: subtract datapath width. `M_SIZE % LIMB == 0` is required.
- `NUM_LIMB`, `M_SIZE/LIMB` (24): number of limbs. This is a localparam.
- `clk` in 1: the single clock. All logic is on the rising edge.
- `rst_n` in 1: asynchronous reset, active-low.
- `mm_done` in 1: one-cycle pulse from the multiplier; `mm_c` and `mm_info` are valid in the same cycle.
- `mm_c` in M_SIZE: unreduced Montgomery product. The design guarantees it is < 2·m.
- `mm_info` in 8: job tag. It is carried unchanged.
- `m` in M_SIZE: modulus. It must be stable while `busy`=1.
- `res_ready` in 1: downstream accepts the result.
- `clr_err` in 1: clears `overflow`.
- `res_valid` out 1: the result is available.
- `res_c` out M_SIZE: reduced result, < m.
- `res_info` out 8: tag belonging to `res_c`.
- `cap_full` out 1: the capture buffer is occupied. Upstream must not pulse `mm_done` while this is high.
- `busy` out 1: the engine state is not IDLE, or `cap_full` is high.
- `overflow` out 1: sticky flag; a done pulse was dropped.

## Operation
- **Capture buffer:** `cap_c`, `cap_info`, `cap_valid`.
  - On `mm_done`, if `cap_valid`=0, or if the engine pops the buffer in the same cycle: load the buffer and set `cap_valid`=1.
  - Otherwise, drop the pulse and set `overflow`=1. The buffered job is unaffected.
- **Engine FSM:** states IDLE, SUB, OUT.
  - IDLE: if `cap_valid`, pop the buffer. Load `c_reg`←`cap_c`, `tag`←`cap_info`, limb index `k`←0, `borrow`←0, then go to SUB. Popping clears `cap_valid` unless a simultaneous capture refills it.
  - SUB: each cycle, compute `{b, d} = c_reg[k] − m[k] − borrow` on LIMB bits. Write `d_reg[k]`←d and `borrow`←b, then increment `k`.
    - When `k`=NUM_LIMB−1: go to OUT. Select `res`←(final borrow ? `c_reg` : `d_reg`).
  - OUT: `res_valid`=1. `res_c` and `res_info` are held constant until the handshake `res_valid & res_ready`; after it, go to IDLE.
- **Arithmetic:** LIMB-bit unsigned subtraction with a 1-bit borrow chain. The final borrow=1 means c < m, so the output is c. Equality c = m yields 0.
- **`overflow`:**
  - Set by a dropped pulse.
  - Cleared by `clr_err`.
  - If set and clear occur in the same cycle, set wins.
- **Reset values:** all state is cleared asynchronously to 0 and the FSM goes to IDLE. All outputs are 0: `res_valid`, `res_c`, `res_info`, `cap_full`, `busy`, `overflow`.
- **Reset mid-operation:** the job in flight and the buffered job are discarded. No partial result is ever presented.

## Timing
- **Latency:**
  - `mm_done` sampled at edge t.
  - `cap_valid`=1 after t.
  - Popped at edge t+1.
  - SUB occupies edges t+2 … t+1+NUM_LIMB.
  - `res_valid`=1 after edge t+1+NUM_LIMB, which is 25 cycles after the done edge with the defaults.
- **Throughput:** one result per NUM_LIMB+1 cycles, plus the OUT dwell time.
- **Second job:** a second `mm_done` may arrive while the engine is in SUB or OUT; it waits in the buffer. A third arrival before the buffer drains sets `overflow`.
- **Same-cycle pop and capture:** the buffer is refilled with the new job and `overflow` stays 0.
- **Output:** `res_valid` stays high until accepted, with no combinational path from `res_ready` to `res_valid`. An accepted result can be followed by a new `res_valid` no earlier than 1+NUM_LIMB cycles later.
- `cap_full` equals `cap_valid` and is registered.

## Test plan
- `mm_c`=m+5, `mm_info`=0x3A, m = 2^3071+ 1 (odd) -> `res_valid` appears 25 cycles after `mm_done` with `res_c`=5 and `res_info`=0x3A.
- Reduction boundaries: `mm_c`=m−1 gives `res_c`=m−1; `mm_c`=m gives 0; `mm_c`=0 gives 0. Also use a borrow-ripple case, `mm_c`=m+2^128 with the low limb of m all ones, giving the correct value.
- Backpressure: hold `res_ready`=0 for 50 cycles -> `res_c`/`res_info` remain stable; `res_valid` drops the cycle after `res_ready`=1.
- Three done pulses spaced 2 cycles apart with `res_ready`=0 -> jobs 1 and 2 are retained and `overflow`=1. `res_ready` then yields tags 1 and 2 in order. `clr_err` clears `overflow`.
- Same-cycle pop and capture: assert `mm_done` in the exact cycle the engine pops the buffer -> no overflow; both results are emitted in order.
- Assert `rst_n`=0 at SUB limb 10 with a buffered job -> all outputs are 0 immediately. After release, with no new `mm_done`, `res_valid` stays 0 for 100 cycles.
